// File: rtl/systolic_pkg.sv
// Shared defaults and state encoding for the systolic array edge feeder.
package systolic_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ACC_W  = 40;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FEED   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } feeder_state_t;

    // Larger of two unsigned sizes; used to find the deepest skew lane.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth data+valid delay line for one array edge lane.
// With FEEDER_ZERO_FILL_EN defined, invalid slots carry zero data.
module skew_delay_line #(
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0][DATA_W-1:0] dat_q, dat_d;

    // Shift every slot one stage toward the output.
    always_comb begin
        vld_d    = '0;
        dat_d    = '0;
        vld_d[0] = valid_i;
`ifdef FEEDER_ZERO_FILL_EN
        dat_d[0] = valid_i ? data_i : '0;
`else
        dat_d[0] = data_i;
`endif
        for (int unsigned k = 1; k < DEPTH; k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = dat_q[k-1];
        end
    end

    // Stage registers; reset clears data as well so edges read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews A columns / B rows onto the left and top edges of a PEX x PEY
// systolic array: lane i is delayed by i+1 cycles after beat acceptance.
// Optional build macro: FEEDER_ZERO_FILL_EN (zero data on invalid lanes).
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PEX    = 2,
    parameter int unsigned PEY    = 2,
    parameter int unsigned KLEN_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [KLEN_W-1:0]         k_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PEX-1:0][DATA_W-1:0] a_vec,
    input  logic [PEY-1:0][DATA_W-1:0] b_vec,
    output logic [PEX-1:0][DATA_W-1:0] a_edge,
    output logic [PEX-1:0]             a_edge_v,
    output logic [PEY-1:0][DATA_W-1:0] b_edge,
    output logic [PEY-1:0]             b_edge_v,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned DEPTH_MAX = max_u(PEX, PEY);
    localparam int unsigned DRAIN_D   = DEPTH_MAX - 1;
    localparam int unsigned DRAIN_W   = (DRAIN_D > 0) ? $clog2(DRAIN_D + 1) : 1;

    feeder_state_t       state_q, state_d;
    logic [KLEN_W-1:0]   klen_q, klen_d;
    logic [KLEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept_c;

    assign accept_c = in_valid && in_ready_q;

    // Next-state logic; status outputs are decoded from the next state so
    // they line up with the registered state.
    always_comb begin
        state_d     = state_q;
        klen_d      = klen_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        klen_d     = k_len;
                        beat_cnt_d = '0;
                        state_d    = FEED;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            FEED: begin
                if (accept_c) begin
                    if (beat_cnt_q == klen_q - KLEN_W'(1)) begin
                        drain_cnt_d = '0;
                        state_d     = DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + KLEN_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Hold until the last beat has left the deepest lane.
                if (drain_cnt_q == DRAIN_W'(DRAIN_D)) begin
                    state_d = FINISH;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d = (state_d == FEED);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FINISH);
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            klen_q      <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            klen_q      <= klen_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Left edge: row i is delayed i+1 cycles.
    for (genvar i = 0; i < PEX; i++) begin : g_a_lane
        skew_delay_line #(
            .DEPTH  (i + 1),
            .DATA_W (DATA_W)
        ) u_dl (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (accept_c),
            .data_i  (a_vec[i]),
            .valid_o (a_edge_v[i]),
            .data_o  (a_edge[i])
        );
    end

    // Top edge: column j is delayed j+1 cycles.
    for (genvar j = 0; j < PEY; j++) begin : g_b_lane
        skew_delay_line #(
            .DEPTH  (j + 1),
            .DATA_W (DATA_W)
        ) u_dl (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (accept_c),
            .data_i  (b_vec[j]),
            .valid_o (b_edge_v[j]),
            .data_o  (b_edge[j])
        );
    end

endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: element width (two's complement).
REQ-002 The block SHALL have parameter PEX, default 2: array rows, one A lane per row.
REQ-003 The block SHALL have parameter PEY, default 2: array columns, one B lane per column.
REQ-004 The block SHALL have parameter KLEN_W, default 16: width of k_len.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins a tile.
REQ-008 The block SHALL have port k_len, input, KLEN_W bits: number of k-beats in the tile, sampled at start.
REQ-009 The block SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): beat handshake.
REQ-010 The block SHALL have ports a_vec (input, [PEX][DATA_W]) and b_vec (input, [PEY][DATA_W]): column k of A and row k of B.
REQ-011 The block SHALL have ports a_edge (output, [PEX][DATA_W]) and a_edge_v (output, [PEX]): left-edge data and valid per row.
REQ-012 The block SHALL have ports b_edge (output, [PEY][DATA_W]) and b_edge_v (output, [PEY]): top-edge data and valid per column.
REQ-013 The block SHALL have port busy, output, 1 bit: a tile is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse when the tile is fully emitted.

Function
REQ-015 The FSM SHALL have the states IDLE, FEED, DRAIN and FINISH.
REQ-016 In IDLE, start with k_len>0 SHALL latch k_len and enter FEED; start with k_len==0 SHALL enter FINISH directly.
REQ-017 In IDLE the block SHALL ignore in_valid and hold in_ready=0.
REQ-018 In FEED, in_ready SHALL be 1; a beat is accepted when in_valid && in_ready is high at a rising edge.
REQ-019 In FEED, cycles with in_valid=0 SHALL insert bubbles that propagate as valid=0 on every lane.
REQ-020 FEED SHALL count accepted beats; on the k_len-th accepted beat, in_ready SHALL drop on the next cycle and the FSM SHALL enter DRAIN.
REQ-021 For a beat accepted at edge n: a_edge[i]/a_edge_v[i] SHALL present a_vec[i] during cycle n+1+i, and b_edge[j]/b_edge_v[j] SHALL present b_vec[j] during cycle n+1+j.
REQ-022 Data SHALL pass through unmodified, with no arithmetic and no width change.
REQ-023 DRAIN SHALL last until the last beat has exited the deepest lane D=max(PEX,PEY)-1; FINISH SHALL then be entered.
REQ-024 With the last beat accepted at edge n, done SHALL be high during cycle n+2+D only.
REQ-025 FINISH SHALL assert done for one cycle and return to IDLE; busy SHALL be 1 in FEED, DRAIN and FINISH.
REQ-026 start while busy SHALL be ignored, and the latched k_len SHALL be unchanged.
REQ-027 A start accepted in the cycle after done SHALL be legal, giving back-to-back tiles with no overlap.

Reset
REQ-028 rst_n low SHALL immediately force: FSM to IDLE, beat count 0, all delay-line valids 0, in_ready=0, busy=0, done=0, all *_edge_v=0 and all *_edge=0.
REQ-029 Reset asserted mid-tile SHALL abort the tile with no done pulse; the first start after release SHALL begin a fresh tile.

Configuration
REQ-030 With FEEDER_ZERO_FILL_EN defined, any *_edge lane whose valid is 0 SHALL drive 0 data.
REQ-031 Without FEEDER_ZERO_FILL_EN, data on invalid lanes SHALL be unspecified (delay-line contents), and consumers SHALL qualify data with valid.

Structure
REQ-032 Package systolic_pkg SHALL hold the DATA_W and ACC_W defaults and the typedef enum feeder_state_t {IDLE, FEED, DRAIN, FINISH}.
REQ-033 Sub-module skew_delay_line (parameters DEPTH, DATA_W; registered data plus valid; reset clears valid) SHALL be instantiated once per lane with DEPTH=lane+1.

Verification
REQ-034 PEX=PEY=2, k_len=3, beats a={1,11},{2,12},{3,13} and b={2,3},{12,13},{22,23} with in_valid continuous from edge n: row0 SHALL emit 1,2,3 on cycles n+1..n+3; row1 SHALL emit 11,12,13 on cycles n+2..n+4; col0 SHALL emit 2,12,22 on cycles n+1..n+3; col1 SHALL emit 3,13,23 on cycles n+2..n+4; done SHALL be high on cycle n+5.
REQ-035 Same tile with in_valid=0 for one cycle after beat 1: every lane SHALL show a single valid=0 gap, and done SHALL shift one cycle later.
REQ-036 start with k_len=0 SHALL produce done exactly one cycle later, with no edge valids and in_ready never 1.
REQ-037 start pulsed during FEED with k_len=5 SHALL be ignored: exactly 3 beats accepted and one done.
REQ-038 rst_n low after beat 2 of a 3-beat tile SHALL clear all edge valids to 0 immediately and produce no done; a new start with k_len=1 and a={7,8}, b={9,10} SHALL complete normally.
REQ-039 FEEDER_ZERO_FILL_EN build: every *_edge lane SHALL read 0 whenever its valid is 0, including during a gap.
